// File: rtl/xif_result_tracker_if.sv
// Bundle of the issue/commit/completion/result signals around the result
// tracker.
//   slave  : the tracker itself (takes alloc/commit/done, drives result/status)
//   master : the surrounding core/pipeline side
// Signals:
//   alloc_valid/ready/id/rd      issue-side allocation handshake
//   commit_valid/id/kill         core commit or kill of an in-flight ID
//   done_valid/id/data           pipeline completion
//   result_valid/ready/id/rd/data in-order result handshake
//   count                        live entries
//   commit_miss                  pulse: last commit matched nothing
interface xif_result_tracker_if #(
  parameter int DEPTH      = 4,
  parameter int X_ID_WIDTH = 4,
  parameter int FLEN       = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  alloc_valid;
  logic                  alloc_ready;
  logic [X_ID_WIDTH-1:0] alloc_id;
  logic [4:0]            alloc_rd;
  logic                  commit_valid;
  logic [X_ID_WIDTH-1:0] commit_id;
  logic                  commit_kill;
  logic                  done_valid;
  logic [X_ID_WIDTH-1:0] done_id;
  logic [FLEN-1:0]       done_data;
  logic                  result_valid;
  logic                  result_ready;
  logic [X_ID_WIDTH-1:0] result_id;
  logic [4:0]            result_rd;
  logic [FLEN-1:0]       result_data;
  logic [CW-1:0]         count;
  logic                  commit_miss;

  modport slave (
    input  alloc_valid, alloc_id, alloc_rd,
    input  commit_valid, commit_id, commit_kill,
    input  done_valid, done_id, done_data,
    input  result_ready,
    output alloc_ready, result_valid, result_id, result_rd, result_data,
    output count, commit_miss
  );

  modport master (
    output alloc_valid, alloc_id, alloc_rd,
    output commit_valid, commit_id, commit_kill,
    output done_valid, done_id, done_data,
    output result_ready,
    input  alloc_ready, result_valid, result_id, result_rd, result_data,
    input  count, commit_miss
  );
endinterface

// File: rtl/xif_result_tracker.sv
// In-order result tracker. Each accepted instruction sits in a circular
// buffer until it has been both committed (or killed) by the core and
// completed by the pipeline; committed+completed entries retire from the
// head in program order, killed entries are dropped one per cycle.
// Ports:
//   ck   clock
//   rst  asynchronous active-low reset
//   bus  xif_result_tracker_if.slave (alloc/commit/done in, result/status out)
module xif_result_tracker #(
  parameter int DEPTH      = 4,
  parameter int X_ID_WIDTH = 4,
  parameter int FLEN       = 32
) (
  input  logic                  ck,
  input  logic                  rst,
  xif_result_tracker_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0]                 r_live, r_cmt, r_kill, r_done;
  logic [DEPTH-1:0][X_ID_WIDTH-1:0] r_id;
  logic [DEPTH-1:0][4:0]            r_rd;
  logic [DEPTH-1:0][FLEN-1:0]       r_data;
  logic [PW-1:0]                    r_head, r_tail;
  logic [CW-1:0]                    r_count;
  logic                             r_miss;

  logic [DEPTH-1:0] w_a_hit, w_c_hit, w_d_hit;
  logic             w_alloc, w_c_new, w_miss_nxt;
  logic             w_hd_kill, w_hd_rdy, w_pop, w_free;

  // Per-entry ID match against the three incoming IDs (live entries only).
  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    assign w_a_hit[g] = r_live[g] && (r_id[g] == bus.alloc_id);
    assign w_c_hit[g] = r_live[g] && (r_id[g] == bus.commit_id);
    assign w_d_hit[g] = r_live[g] && (r_id[g] == bus.done_id);
  end

  // Space is judged from registered count only, so a same-cycle pop never
  // makes room for a same-cycle allocation.
  assign bus.alloc_ready = (r_count != CW'(DEPTH)) && !(|w_a_hit);
  assign w_alloc         = bus.alloc_valid && bus.alloc_ready;

  // A commit may target the entry being allocated this very cycle. Live IDs
  // are unique and an accepted alloc_id matches no live entry, so at most one
  // of w_c_hit / w_c_new can be set.
  assign w_c_new    = bus.commit_valid && w_alloc && (bus.alloc_id == bus.commit_id);
  assign w_miss_nxt = bus.commit_valid && !(|w_c_hit) && !w_c_new;

  assign w_hd_kill = r_live[r_head] && r_kill[r_head];
  assign w_hd_rdy  = r_live[r_head] && r_cmt[r_head] && r_done[r_head] && !r_kill[r_head];
  assign w_pop     = w_hd_rdy && bus.result_ready;
  assign w_free    = w_hd_kill || w_pop;

  assign bus.result_valid = w_hd_rdy;
  assign bus.result_id    = w_hd_rdy ? r_id[r_head]   : '0;
  assign bus.result_rd    = w_hd_rdy ? r_rd[r_head]   : '0;
  assign bus.result_data  = w_hd_rdy ? r_data[r_head] : '0;
  assign bus.count        = r_count;
  assign bus.commit_miss  = r_miss;

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      r_live  <= '0;
      r_cmt   <= '0;
      r_kill  <= '0;
      r_done  <= '0;
      r_id    <= '0;
      r_rd    <= '0;
      r_data  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_miss  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // Only the first commit/kill on an entry takes effect.
        if (bus.commit_valid && w_c_hit[i] && !r_cmt[i] && !r_kill[i]) begin
          r_cmt[i]  <= !bus.commit_kill;
          r_kill[i] <= bus.commit_kill;
        end
        if (bus.done_valid && w_d_hit[i] && !r_kill[i]) begin
          r_done[i] <= 1'b1;
          r_data[i] <= bus.done_data;
        end
      end
      if (w_free) begin
        r_live[r_head] <= 1'b0;
        r_head         <= r_head + PW'(1);
      end
      // Tail differs from a live head whenever alloc is allowed (not full).
      if (w_alloc) begin
        r_live[r_tail] <= 1'b1;
        r_id[r_tail]   <= bus.alloc_id;
        r_rd[r_tail]   <= bus.alloc_rd;
        r_cmt[r_tail]  <= w_c_new && !bus.commit_kill;
        r_kill[r_tail] <= w_c_new && bus.commit_kill;
        r_done[r_tail] <= 1'b0;
        r_data[r_tail] <= '0;
        r_tail         <= r_tail + PW'(1);
      end
      r_count <= r_count + CW'(w_alloc) - CW'(w_free);
      r_miss  <= w_miss_nxt;
    end
  end
endmodule

// File: tb/tb_xif_result_tracker.sv
module tb_xif_result_tracker;
  localparam int DEPTH = 4;
  localparam int XW    = 4;
  localparam int FLEN  = 32;

  logic ck  = 1'b0;
  logic rst = 1'b0;
  always #5 ck = ~ck;

  xif_result_tracker_if #(.DEPTH(DEPTH), .X_ID_WIDTH(XW), .FLEN(FLEN)) bus();
  xif_result_tracker #(.DEPTH(DEPTH), .X_ID_WIDTH(XW), .FLEN(FLEN)) dut (
    .ck(ck), .rst(rst), .bus(bus)
  );

  // Program-ordered list of in-flight instructions.
  typedef struct {
    logic [XW-1:0]   id;
    logic [4:0]      rd;
    bit              cmt, kil, dn;
    logic [FLEN-1:0] data;
  } ent_t;
  typedef struct {
    logic [XW-1:0]   id;
    logic [4:0]      rd;
    logic [FLEN-1:0] data;
  } res_t;

  ent_t mq[$];
  res_t exp_q[$];
  int   n_cmp = 0, n_err = 0;
  bit   chk_en = 0;
  bit   e_ardy, e_miss, e_rv;
  int   e_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int find(input logic [XW-1:0] id);
    for (int i = 0; i < mq.size(); i++) if (mq[i].id == id) return i;
    return -1;
  endfunction

  function automatic bit model_ardy(input logic [XW-1:0] id);
    return (mq.size() < DEPTH) && (find(id) < 0);
  endfunction

  function automatic bit head_ready();
    return (mq.size() > 0) && mq[0].cmt && mq[0].dn && !mq[0].kil;
  endfunction

  // Apply the inputs that were held through the edge just past.
  task automatic step_model();
    bit acc, drop, miss, newc, newk;
    int h;
    acc = bus.alloc_valid && model_ardy(bus.alloc_id);
    drop = 0; miss = 0; newc = 0; newk = 0;
    if (mq.size() > 0 && (mq[0].kil || (head_ready() && bus.result_ready))) drop = 1;
    if (bus.commit_valid) begin
      h = find(bus.commit_id);
      if (h >= 0) begin
        if (!mq[h].cmt && !mq[h].kil) begin
          if (bus.commit_kill) mq[h].kil = 1; else mq[h].cmt = 1;
        end
      end else if (acc && bus.alloc_id == bus.commit_id) begin
        newk = bus.commit_kill;
        newc = !bus.commit_kill;
      end else miss = 1;
    end
    if (bus.done_valid) begin
      h = find(bus.done_id);
      if (h >= 0 && !mq[h].kil) begin
        mq[h].dn   = 1;
        mq[h].data = bus.done_data;
      end
    end
    if (drop) void'(mq.pop_front());
    if (acc) mq.push_back('{id: bus.alloc_id, rd: bus.alloc_rd, cmt: newc, kil: newk, dn: 0, data: '0});
    e_miss = miss;
  endtask

  function automatic logic [XW-1:0] pick_id(input logic [XW-1:0] aid);
    int r;
    r = $urandom_range(0, 7);
    if (r < 5 && mq.size() > 0) return mq[$urandom_range(0, mq.size() - 1)].id;
    if (r == 5) return aid;
    return XW'($urandom_range(0, 15));
  endfunction

  // Monitor: compares status each cycle and pops the scoreboard on each
  // accepted result.
  initial begin
    res_t r;
    forever begin
      @(negedge ck);
      if (chk_en) begin
        chk("alloc_ready", bus.alloc_ready, e_ardy);
        chk("count", bus.count, e_cnt);
        chk("commit_miss", bus.commit_miss, e_miss);
        chk("result_valid", bus.result_valid, e_rv);
        if (bus.result_valid && bus.result_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL result_unexpected: got id %0h expected no result", bus.result_id);
          end else begin
            r = exp_q.pop_front();
            chk("result_id", bus.result_id, r.id);
            chk("result_rd", bus.result_rd, r.rd);
            chk("result_data", bus.result_data, r.data);
          end
        end else if (!bus.result_valid) begin
          chk("result_idle_zero", {bus.result_id, bus.result_rd, bus.result_data}, 0);
        end
      end
    end
  end

  // Driver + reference model.
  initial begin
    int p;
    bus.alloc_valid = 0; bus.alloc_id = 0; bus.alloc_rd = 0;
    bus.commit_valid = 0; bus.commit_id = 0; bus.commit_kill = 0;
    bus.done_valid = 0; bus.done_id = 0; bus.done_data = 0;
    bus.result_ready = 0;
    repeat (2) @(posedge ck);
    #1;
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_alloc_ready", bus.alloc_ready, 1);
    chk("rst_commit_miss", bus.commit_miss, 0);
    chk("rst_result_data", bus.result_data, 0);
    rst = 1;
    e_cnt = 0; e_ardy = 1; e_miss = 0; e_rv = 0;
    chk_en = 1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge ck);
      #1;
      step_model();
      if (cyc == 1500) begin
        // Asynchronous reset in the middle of a result_ready=0 hold.
        rst = 0;
        #1;
        chk("midrst_result_valid", bus.result_valid, 0);
        chk("midrst_count", bus.count, 0);
        mq.delete();
        exp_q.delete();
        e_miss = 0;
        #1;
        rst = 1;
      end
      p = (cyc / 250) % 3;
      bus.result_ready = (p == 0) ? ($urandom_range(0, 9) < 9) :
                         (p == 1) ? ($urandom_range(0, 1) == 1) :
                                    ($urandom_range(0, 9) == 0);
      if (cyc >= 1490 && cyc < 1500) bus.result_ready = 0;
      bus.alloc_valid  = ($urandom_range(0, 3) != 0);
      bus.alloc_id     = XW'($urandom_range(0, 7));
      bus.alloc_rd     = 5'($urandom_range(0, 31));
      bus.commit_valid = ($urandom_range(0, 2) == 0);
      bus.commit_id    = pick_id(bus.alloc_id);
      bus.commit_kill  = ($urandom_range(0, 3) == 0);
      bus.done_valid   = ($urandom_range(0, 1) == 1);
      bus.done_id      = pick_id(bus.alloc_id);
      bus.done_data    = FLEN'($urandom);
      e_cnt  = mq.size();
      e_ardy = model_ardy(bus.alloc_id);
      e_rv   = head_ready();
      if (e_rv && bus.result_ready)
        exp_q.push_back('{id: mq[0].id, rd: mq[0].rd, data: mq[0].data});
    end
    @(negedge ck);
    #1;
    chk_en = 0;
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
